// File: rtl/dmem_img_reader_if.sv
// Bus bundle between the image reader, data memory and the pixel consumer.
// The master side belongs to the reader: it drives the DMEM read strobe and address
// and presents the pixel stream; the slave side is memory plus consumer.
interface dmem_img_reader_if;
  logic         dmem_rden;
  logic [6:0]   dmem_rdaddr;
  logic [255:0] dmem_rddata;
  logic         pxl_valid;
  logic         pxl_ready;
  logic [7:0]   pxl_data;
  logic [4:0]   pxl_row;
  logic [4:0]   pxl_col;
  logic         pxl_eol;
  logic         pxl_last;

  modport master (
    output dmem_rden, dmem_rdaddr,
    input  dmem_rddata,
    output pxl_valid, pxl_data, pxl_row, pxl_col, pxl_eol, pxl_last,
    input  pxl_ready
  );

  modport slave (
    input  dmem_rden, dmem_rdaddr,
    output dmem_rddata,
    input  pxl_valid, pxl_data, pxl_row, pxl_col, pxl_eol, pxl_last,
    output pxl_ready
  );
endinterface

// File: rtl/dmem_img_reader.sv
// Streams a stored grayscale image out of DMEM, one 8-bit pixel per handshake,
// row-major. The first word is fetched before streaming starts; afterwards a
// single-word prefetch buffer keeps the output register fed so that a consumer
// holding ready sees one pixel per clock with no bubble at word boundaries.
module dmem_img_reader #(
  parameter int NUM_PIXELS   = 784,
  parameter int PIX_PER_WORD = 16,
  parameter int IMG_WIDTH    = 28,
  parameter int BASE_ADDR    = 0
) (
  input  logic CLOCK_50,
  input  logic rst,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  dmem_img_reader_if.master bus
);

  localparam int         LANE_W      = 256 / PIX_PER_WORD;
  localparam logic [7:0] NUM_WORDS_C = 8'(NUM_PIXELS / PIX_PER_WORD);
  localparam logic [6:0] BASE_C      = 7'(BASE_ADDR);
  localparam logic [9:0] LAST_PIX_C  = 10'(NUM_PIXELS - 1);
  localparam logic [4:0] LAST_COL_C  = 5'(IMG_WIDTH - 1);
  localparam logic [3:0] LAST_LANE_C = 4'(PIX_PER_WORD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH0 = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t       state_r;
  logic         busy_r;
  logic         done_r;
  logic         rden_r;
  logic [6:0]   rdaddr_r;
  logic         data_vld_r;   // dmem_rddata carries the word requested last cycle
  logic [7:0]   words_r;      // reads issued for the current image
  logic [255:0] out_r;        // current word, presented lane sits in [7:0]
  logic [255:0] buf_r;
  logic         buf_full_r;
  logic [3:0]   lane_r;
  logic [9:0]   pix_r;
  logic [4:0]   row_r;
  logic [4:0]   col_r;
  logic         eol_r;
  logic         last_r;
  logic         valid_r;

  logic         hs_s;
  logic         can_fetch_s;
  logic [9:0]   pix_nxt_s;
  logic [4:0]   row_nxt_s;
  logic [4:0]   col_nxt_s;

  assign hs_s        = valid_r & bus.pxl_ready;
  assign can_fetch_s = !buf_full_r && !rden_r && !data_vld_r && (words_r < NUM_WORDS_C);

  // Raster position of the pixel that follows the one currently presented.
  always_comb begin
    pix_nxt_s = pix_r + 10'd1;
    if (col_r == LAST_COL_C) begin
      col_nxt_s = 5'd0;
      row_nxt_s = row_r + 5'd1;
    end else begin
      col_nxt_s = col_r + 5'd1;
      row_nxt_s = row_r;
    end
  end

  // Read-out sequencer: FSM, DMEM read strobes, prefetch buffer and pixel registers.
  always_ff @(posedge CLOCK_50) begin
    if (rst || (abort && (state_r != IDLE))) begin
      // Reset and abort both drop everything, including any word still in flight.
      state_r    <= IDLE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      rden_r     <= 1'b0;
      rdaddr_r   <= 7'd0;
      data_vld_r <= 1'b0;
      words_r    <= 8'd0;
      out_r      <= 256'd0;
      buf_r      <= 256'd0;
      buf_full_r <= 1'b0;
      lane_r     <= 4'd0;
      pix_r      <= 10'd0;
      row_r      <= 5'd0;
      col_r      <= 5'd0;
      eol_r      <= 1'b0;
      last_r     <= 1'b0;
      valid_r    <= 1'b0;
    end else begin
      rden_r     <= 1'b0;
      done_r     <= 1'b0;
      data_vld_r <= rden_r;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r    <= FETCH0;
            busy_r     <= 1'b1;
            rden_r     <= 1'b1;
            rdaddr_r   <= BASE_C;
            words_r    <= 8'd1;
            buf_full_r <= 1'b0;
            lane_r     <= 4'd0;
            pix_r      <= 10'd0;
            row_r      <= 5'd0;
            col_r      <= 5'd0;
            eol_r      <= (LAST_COL_C == 5'd0);
            last_r     <= (LAST_PIX_C == 10'd0);
            valid_r    <= 1'b0;
          end else begin
            state_r <= IDLE;
          end
        end
        FETCH0: begin
          // First word goes straight to the output register; prefetch of the next starts now.
          if (data_vld_r) begin
            out_r   <= bus.dmem_rddata;
            valid_r <= 1'b1;
            state_r <= STREAM;
            if (words_r < NUM_WORDS_C) begin
              rden_r   <= 1'b1;
              rdaddr_r <= BASE_C + words_r[6:0];
              words_r  <= words_r + 8'd1;
            end
          end
        end
        STREAM: begin
          if (data_vld_r) begin
            buf_r      <= bus.dmem_rddata;
            buf_full_r <= 1'b1;
          end
          if (can_fetch_s) begin
            rden_r   <= 1'b1;
            rdaddr_r <= BASE_C + words_r[6:0];
            words_r  <= words_r + 8'd1;
          end
          if (hs_s) begin
            if (pix_r == LAST_PIX_C) begin
              state_r <= DONE;
              valid_r <= 1'b0;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              pix_r  <= pix_nxt_s;
              row_r  <= row_nxt_s;
              col_r  <= col_nxt_s;
              eol_r  <= (col_nxt_s == LAST_COL_C);
              last_r <= (pix_nxt_s == LAST_PIX_C);
              if (lane_r == LAST_LANE_C) begin
                lane_r <= 4'd0;
                if (buf_full_r) begin
                  out_r      <= buf_r;
                  buf_full_r <= 1'b0;
                end else if (data_vld_r) begin
                  // Word arrives on the same edge it is needed: bypass the buffer.
                  out_r      <= bus.dmem_rddata;
                  buf_full_r <= 1'b0;
                end else begin
                  valid_r <= 1'b0;
                end
              end else begin
                out_r  <= out_r >> LANE_W;
                lane_r <= lane_r + 4'd1;
              end
            end
          end else if (!valid_r) begin
            // Stalled on a late word: resume as soon as it is available.
            if (buf_full_r) begin
              out_r      <= buf_r;
              buf_full_r <= 1'b0;
              valid_r    <= 1'b1;
            end else if (data_vld_r) begin
              out_r      <= bus.dmem_rddata;
              buf_full_r <= 1'b0;
              valid_r    <= 1'b1;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy            = busy_r;
  assign done            = done_r;
  assign bus.dmem_rden   = rden_r;
  assign bus.dmem_rdaddr = rdaddr_r;
  assign bus.pxl_valid   = valid_r;
  assign bus.pxl_data    = out_r[7:0];
  assign bus.pxl_row     = row_r;
  assign bus.pxl_col     = col_r;
  assign bus.pxl_eol     = eol_r;
  assign bus.pxl_last    = last_r;

endmodule

// File: tb/tb_dmem_img_reader.sv
// Self-checking bench for dmem_img_reader: a 1-cycle-latency DMEM model answers
// reads, and a reference model derives every pixel, row, column and flag from the
// image layout (word base+i/16, lane i%16, row i/28, column i%28).
module tb_dmem_img_reader;

  logic CLOCK_50 = 1'b0;
  logic rst, start, abort, busy, done;
  logic start2, abort2, busy2, done2;
  logic log_clr;

  dmem_img_reader_if bus1 ();
  dmem_img_reader_if bus2 ();

  logic [255:0] mem [0:127];
  logic [6:0]   rd_q1[$];
  logic [6:0]   rd_q2[$];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;
  int idx2      = 0;
  int mis2      = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  dmem_img_reader #(.NUM_PIXELS(784), .PIX_PER_WORD(16), .IMG_WIDTH(28), .BASE_ADDR(0)) dut (
    .CLOCK_50(CLOCK_50), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .bus(bus1)
  );

  dmem_img_reader #(.NUM_PIXELS(784), .PIX_PER_WORD(16), .IMG_WIDTH(28), .BASE_ADDR(64)) dut2 (
    .CLOCK_50(CLOCK_50), .rst(rst), .start(start2), .abort(abort2),
    .busy(busy2), .done(done2), .bus(bus2)
  );

  // DMEM model for the first reader: data one cycle after the strobe, junk otherwise.
  always @(posedge CLOCK_50) begin
    if (log_clr) rd_q1.delete();
    else if (bus1.dmem_rden) rd_q1.push_back(bus1.dmem_rdaddr);
    if (bus1.dmem_rden) bus1.dmem_rddata <= mem[bus1.dmem_rdaddr];
    else bus1.dmem_rddata <= {8{$urandom}};
  end

  // DMEM model for the second reader.
  always @(posedge CLOCK_50) begin
    if (log_clr) rd_q2.delete();
    else if (bus2.dmem_rden) rd_q2.push_back(bus2.dmem_rdaddr);
    if (bus2.dmem_rden) bus2.dmem_rddata <= mem[bus2.dmem_rdaddr];
    else bus2.dmem_rddata <= {8{$urandom}};
  end

  // Reference pixel for image index i: {last, eol, row, col, data}.
  function automatic logic [19:0] exp_pix(input int base, input int i);
    logic [255:0] w;
    int col;
    w   = mem[base + i / 16];
    col = i % 28;
    return {(i == 783), (col == 27), 5'(i / 28), 5'(col), w[16 * (i % 16) +: 8]};
  endfunction

  function automatic logic [19:0] obs_pix1();
    return {bus1.pxl_last, bus1.pxl_eol, bus1.pxl_row, bus1.pxl_col, bus1.pxl_data};
  endfunction

  function automatic logic [19:0] obs_pix2();
    return {bus2.pxl_last, bus2.pxl_eol, bus2.pxl_row, bus2.pxl_col, bus2.pxl_data};
  endfunction

  function automatic logic [31:0] outs1();
    return {1'b0, busy, done, bus1.dmem_rden, bus1.dmem_rdaddr, bus1.pxl_valid, bus1.pxl_data,
            bus1.pxl_row, bus1.pxl_col, bus1.pxl_eol, bus1.pxl_last};
  endfunction

  // Second reader consumes at full rate; compare each accepted pixel with the model.
  always @(negedge CLOCK_50) begin
    if (start2) begin
      idx2 <= 0;
      mis2 <= 0;
    end else if (bus2.pxl_valid && bus2.pxl_ready) begin
      if (obs_pix2() !== exp_pix(64, idx2)) mis2 <= mis2 + 1;
      idx2 <= idx2 + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reads(input string tag, input int which, input int base);
    int bad;
    int n;
    logic [6:0] a;
    bad = 0;
    n = (which == 1) ? rd_q1.size() : rd_q2.size();
    for (int k = 0; k < n; k++) begin
      a = (which == 1) ? rd_q1[k] : rd_q2[k];
      if (int'(a) != base + k) bad++;
    end
    check({tag, "_count"}, 32'(n), 32'd49);
    check({tag, "_addr"}, 32'(bad), 32'd0);
  endtask

  task automatic fill_mem(input bit pattern);
    logic [255:0] w;
    for (int k = 0; k < 128; k++) begin
      for (int j = 0; j < 16; j++) begin
        if (pattern) w[16 * j +: 16] = {8'($urandom), 8'((16 * k + j) & 255)};
        else w[16 * j +: 16] = 16'($urandom);
      end
      mem[k] = w;
    end
  endtask

  // Pulse start (with read-log clear) and land #1 into cycle N+1; check its outputs.
  task automatic begin_image(input string tag);
    start   = 1'b1;
    log_clr = 1'b1;
    @(posedge CLOCK_50); #1;
    start   = 1'b0;
    log_clr = 1'b0;
    check({tag, "_n1_busy"}, 32'(busy), 32'd1);
    check({tag, "_n1_rden"}, 32'(bus1.dmem_rden), 32'd1);
    check({tag, "_n1_addr"}, 32'(bus1.dmem_rdaddr), 32'd0);
  endtask

  // Drive the consumer from cycle N+1 until done, abort, reset or budget expiry.
  task automatic stream(input int ready_pct, input int abort_at, input int rst_at,
                        input bit poke, output int done_cyc, output int first_vld);
    int  idx, cyc, bad_busy;
    bit  hs, stop, do_abort, do_rst;
    idx = 0; cyc = 1; bad_busy = 0; stop = 1'b0;
    done_cyc = -1; first_vld = -1;
    while (!stop) begin
      do_abort = 1'b0;
      do_rst   = 1'b0;
      bus1.pxl_ready = (int'($urandom_range(99)) < ready_pct);
      if (cyc == 3) begin
        check("prefetch_rden", 32'(bus1.dmem_rden), 32'd1);
        check("prefetch_addr", 32'(bus1.dmem_rdaddr), 32'd1);
      end
      if (bus1.pxl_valid) begin
        if (first_vld < 0) first_vld = cyc;
        check($sformatf("pix%0d", idx), 32'(obs_pix1()), 32'(exp_pix(0, idx)));
        if (idx == abort_at) begin
          do_abort = 1'b1;
          abort = 1'b1;
          bus1.pxl_ready = 1'b1;
        end
        if (idx == rst_at) begin
          do_rst = 1'b1;
          rst = 1'b1;
        end
        if (poke && idx == 300) start = 1'b1;
      end
      hs = bus1.pxl_valid && bus1.pxl_ready;
      @(posedge CLOCK_50); #1;
      cyc++;
      start = 1'b0;
      if (do_abort) begin
        abort = 1'b0;
        check("abort_valid_busy_done", {29'd0, bus1.pxl_valid, busy, done}, 32'd0);
        stop = 1'b1;
      end else if (do_rst) begin
        check("rst_outputs", outs1(), 32'd0);
        rst = 1'b0;
        stop = 1'b1;
      end else begin
        if (hs) idx++;
        if (done) begin
          done_cyc = cyc;
          check("done_pixels", 32'(idx), 32'd784);
          check("busy_during_stream", 32'(bad_busy), 32'd0);
          stop = 1'b1;
        end else if (!busy) begin
          bad_busy++;
        end
        if (!stop && cyc > 4000) begin
          check("stream_timeout", 32'(idx), 32'd784);
          stop = 1'b1;
        end
      end
    end
    bus1.pxl_ready = 1'b0;
  endtask

  initial begin
    int dc, fv, waited;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    start2 = 1'b0; abort2 = 1'b0; log_clr = 1'b0;
    bus1.pxl_ready = 1'b0;
    bus2.pxl_ready = 1'b1;
    fill_mem(1'b1);
    repeat (3) @(posedge CLOCK_50);
    #1;
    check("reset_outputs", outs1(), 32'd0);
    check("reset_busy2", 32'(busy2), 32'd0);
    rst = 1'b0;
    @(posedge CLOCK_50); #1;

    // Full-rate run on the counting pattern, with start poked mid-stream and in DONE.
    begin_image("full");
    stream(100, -1, -1, 1'b1, dc, fv);
    check("first_valid_cycle", 32'(fv), 32'd3);
    check("done_cycle", 32'(dc), 32'd787);
    start = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    check("start_in_done_ignored", {29'd0, busy, done, bus1.dmem_rden}, 32'd0);
    check_reads("full_reads", 1, 0);

    // Random image, consumer ready half the time.
    fill_mem(1'b0);
    begin_image("rand");
    stream(50, -1, -1, 1'b0, dc, fv);
    check("rand_completed", 32'(dc > 0), 32'd1);
    @(posedge CLOCK_50); #1;
    check("rand_done_one_cycle", {30'd0, busy, done}, 32'd0);
    check_reads("rand_reads", 1, 0);

    // Abort at pixel 100 with a simultaneous handshake, then a clean restart.
    begin_image("abort");
    stream(60, 100, -1, 1'b0, dc, fv);
    @(posedge CLOCK_50); #1;
    check("post_abort_quiet", {29'd0, busy, done, bus1.dmem_rden}, 32'd0);
    begin_image("restart");
    stream(100, -1, -1, 1'b0, dc, fv);
    check("restart_done_cycle", 32'(dc), 32'd787);
    check_reads("restart_reads", 1, 0);
    @(posedge CLOCK_50); #1;

    // Reset at pixel 500.
    begin_image("rst");
    stream(100, -1, 500, 1'b0, dc, fv);
    @(posedge CLOCK_50); #1;
    check("post_rst_idle", outs1(), 32'd0);

    // Second reader placed at word 64.
    fill_mem(1'b1);
    start2  = 1'b1;
    log_clr = 1'b1;
    @(posedge CLOCK_50); #1;
    start2  = 1'b0;
    log_clr = 1'b0;
    check("base64_n1_addr", {24'd0, bus2.dmem_rden, bus2.dmem_rdaddr}, {24'd0, 1'b1, 7'd64});
    waited = 0;
    while (!done2 && waited < 2000) begin
      @(posedge CLOCK_50); #1;
      waited++;
    end
    check("base64_done_seen", 32'(done2), 32'd1);
    check("base64_pixels", 32'(idx2), 32'd784);
    check("base64_pixel_errors", 32'(mis2), 32'd0);
    check_reads("base64_reads", 2, 64);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
